// File: rtl/aia_msi_pkg.sv
// Shared constants, types and helpers for the AIA MSI capture block.
package aia_msi_pkg;

  localparam int unsigned PAGE_SHIFT = 12;

  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
  localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

  // Packed width of one queued MSI {file, id}.
  function automatic int unsigned msi_entry_w(input int unsigned file_w,
                                              input int unsigned src_w);
    return file_w + src_w;
  endfunction

  // Reverse byte order of a 32-bit word (seteipnum_be payload).
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aia_msi_fifo.sv
// Generic synchronous FIFO; a push while full is accepted when a pop happens the same cycle.
module aia_msi_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0],
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pop_ok_c  = pop_i & ~empty_o;
    push_ok_c = push_i & (~full_o | pop_ok_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = CNT_W'(cnt_q + 1'b1);
      2'b01:   cnt_d = CNT_W'(cnt_q - 1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/aia_msi_capture.sv
// Decodes IMSIC seteipnum writes from the register strobe and queues {file, id} MSIs.
module aia_msi_capture
  import aia_msi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned NR_INTP_FILES  = 2,
  parameter int unsigned NR_SRC_W       = 6,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned FILE_W = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic                      msi_valid_o,
  input  logic                      msi_ready_i,
  output logic [FILE_W-1:0]         msi_file_o,
  output logic [NR_SRC_W-1:0]       msi_id_o,
  output logic [CNT_W-1:0]          drop_cnt_o,
  output logic                      overflow_o
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [FILE_W-1:0]   file;
    logic [NR_SRC_W-1:0] id;
  } msi_entry_t;

  // Elaboration-time parameter legality.
  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_dw
    $error("aia_msi_capture: AXI_DATA_WIDTH must be 32 or 64");
  end
  if ($bits(msi_entry_t) != msi_entry_w(FILE_W, NR_SRC_W)) begin : g_bad_entry
    $error("aia_msi_capture: msi_entry_t width mismatch");
  end

  logic [11:0]       offset_c;
  logic [31:0]       word_c;
  logic [31:0]       id_raw_c;
  logic [FILE_W-1:0] file_c;
  logic              is_le_c;
  logic              is_be_c;
  logic              id_ok_c;
  logic              push_req_c;
  logic              pop_c;
  logic              drop_c;
  msi_entry_t        entry_c;
  msi_entry_t        head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [FCNT_W-1:0] fifo_count_unused;
  logic              unused_c;

  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  // seteipnum registers always read as zero.
  assign rdata_o = '0;

  // Pick the 32-bit word addressed inside the data bus.
  if (AXI_DATA_WIDTH == 64) begin : g_lane64
    assign word_c = addr_i[2] ? wdata_i[63:32] : wdata_i[31:0];
  end else begin : g_lane32
    assign word_c = wdata_i[31:0];
  end

  // Interrupt-file page select; the upper address bits were decoded upstream.
  if (NR_INTP_FILES > 1) begin : g_file
    assign file_c = addr_i[PAGE_SHIFT +: FILE_W];
  end else begin : g_file1
    assign file_c = '0;
  end

  // Register match, identity validation and push request.
  always_comb begin
    offset_c   = addr_i[11:0];
    is_le_c    = (offset_c == SETEIPNUM_LE_OFF);
    is_be_c    = (offset_c == SETEIPNUM_BE_OFF);
    id_raw_c   = is_be_c ? bswap32(word_c) : word_c;
    id_ok_c    = (id_raw_c != 32'd0) && ((id_raw_c >> NR_SRC_W) == 32'd0);
    push_req_c = en_i & we_i & (is_le_c | is_be_c) & id_ok_c;
    entry_c    = '{file: file_c, id: id_raw_c[NR_SRC_W-1:0]};
  end

  aia_msi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (msi_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req_c),
    .data_i  (entry_c),
    .pop_i   (pop_c),
    .data_o  (head_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .count_o (fifo_count_unused)
  );

  assign msi_valid_o = ~fifo_empty_c;
  assign msi_file_o  = head_c.file;
  assign msi_id_o    = head_c.id;
  assign pop_c       = ~fifo_empty_c & msi_ready_i;

  // A push lost to a full FIFO bumps the saturating counter and sets the sticky flag.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    drop_c     = push_req_c & fifo_full_c & ~pop_c;
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = CNT_W'(drop_cnt_q + 1'b1);
      end
    end
  end

  // Drop bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

  // Address bits outside the page/lane decode and unselected data are intentionally unused.
  assign unused_c = ^{addr_i, wdata_i, fifo_count_unused};

endmodule
